// File: rtl/regwrite_arbiter_if.sv
// Register-file write-port bundle: writeback and multiplier request/ack pairs,
// the registered write port toward register_memory, and the Decode stall status.
interface regwrite_arbiter_if #(
    parameter int WORD     = 64,
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
);
    logic                wb_req;
    logic [REG_BITS-1:0] wb_reg;
    logic [WORD-1:0]     wb_data;
    logic                wb_ack;
    logic                mul_req;
    logic [REG_BITS-1:0] mul_reg;
    logic [WORD-1:0]     mul_data;
    logic                mul_ack;
    logic                reg_write;
    logic [REG_BITS-1:0] write_reg;
    logic [WORD-1:0]     write_data;
    logic                stall;
    logic [CNT_BITS-1:0] stall_cycles;

    modport master (
        output wb_req, wb_reg, wb_data, mul_req, mul_reg, mul_data,
        input  wb_ack, mul_ack, reg_write, write_reg, write_data, stall, stall_cycles
    );

    modport slave (
        input  wb_req, wb_reg, wb_data, mul_req, mul_reg, mul_data,
        output wb_ack, mul_ack, reg_write, write_reg, write_data, stall, stall_cycles
    );
endinterface

// File: rtl/regwrite_arbiter.sv
// Arbitrates the single register-file write port between writeback and the
// multiplier; a colliding multiplier result is parked for one cycle in a hold buffer.
module regwrite_arbiter #(
    parameter int WORD     = 64,
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    regwrite_arbiter_if.slave bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;
    localparam logic [REG_BITS-1:0] ZERO_IDX = REG_BITS'(ZERO_REG);

    logic [0:0]          state_reg, state_next;
    logic [REG_BITS-1:0] hold_reg_reg, hold_reg_next;
    logic [WORD-1:0]     hold_data_reg, hold_data_next;
    logic                reg_write_reg, reg_write_next;
    logic [REG_BITS-1:0] write_reg_reg, write_reg_next;
    logic [WORD-1:0]     write_data_reg, write_data_next;
    logic [CNT_BITS-1:0] stall_cycles_reg;
    logic                wb_grant, mul_grant;
    logic                wb_zero, mul_zero;

    assign wb_zero  = (bus.wb_reg == ZERO_IDX);
    assign mul_zero = (bus.mul_reg == ZERO_IDX);

    always_comb begin
        state_next      = EMPTY;
        hold_reg_next   = hold_reg_reg;
        hold_data_next  = hold_data_reg;
        reg_write_next  = 1'b0;
        write_reg_next  = '0;
        write_data_next = '0;
        wb_grant        = 1'b0;
        mul_grant       = 1'b0;
        if (state_reg == HOLD) begin
            // Drain the parked multiplier result; both requesters wait this cycle.
            reg_write_next  = 1'b1;
            write_reg_next  = hold_reg_reg;
            write_data_next = hold_data_reg;
        end else begin
            wb_grant  = bus.wb_req;
            mul_grant = bus.mul_req;
            if (bus.wb_req && !wb_zero) begin
                reg_write_next  = 1'b1;
                write_reg_next  = bus.wb_reg;
                write_data_next = bus.wb_data;
                // Same-destination mul is older than wb and is simply dropped.
                if (bus.mul_req && !mul_zero && (bus.mul_reg != bus.wb_reg)) begin
                    hold_reg_next  = bus.mul_reg;
                    hold_data_next = bus.mul_data;
                    state_next     = HOLD;
                end
            end else if (bus.mul_req && !mul_zero) begin
                reg_write_next  = 1'b1;
                write_reg_next  = bus.mul_reg;
                write_data_next = bus.mul_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= EMPTY;
            hold_reg_reg     <= '0;
            hold_data_reg    <= '0;
            reg_write_reg    <= 1'b0;
            write_reg_reg    <= '0;
            write_data_reg   <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_reg_reg   <= hold_reg_next;
            hold_data_reg  <= hold_data_next;
            reg_write_reg  <= reg_write_next;
            write_reg_reg  <= write_reg_next;
            write_data_reg <= write_data_next;
            if ((state_reg == HOLD) && (stall_cycles_reg != {CNT_BITS{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
        end
    end

    assign bus.wb_ack       = wb_grant;
    assign bus.mul_ack      = mul_grant;
    assign bus.reg_write    = reg_write_reg;
    assign bus.write_reg    = write_reg_reg;
    assign bus.write_data   = write_data_reg;
    assign bus.stall        = (state_reg == HOLD);
    assign bus.stall_cycles = stall_cycles_reg;
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Randomized and directed bench for regwrite_arbiter, checked every cycle
// against a queue-based model of which writes must reach the register file.
module tb_regwrite_arbiter;
    localparam int WORD     = 64;
    localparam int REG_BITS = 5;
    localparam int ZERO_REG = 31;
    localparam int CNT_BITS = 8;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    typedef struct {
        logic [REG_BITS-1:0] r;
        logic [WORD-1:0]     d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regwrite_arbiter_if #(.WORD(WORD), .REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) bus ();

    regwrite_arbiter #(
        .WORD(WORD), .REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: what is on the write port now, and what is still owed to it.
    logic                m_rw;
    logic [REG_BITS-1:0] m_wr;
    logic [WORD-1:0]     m_wd;
    logic                m_pend;
    wr_t                 m_pend_w;
    int                  m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rw     = 1'b0;
        m_wr     = '0;
        m_wd     = '0;
        m_pend   = 1'b0;
        m_pend_w = '{r: '0, d: '0};
        m_cnt    = 0;
    endtask

    task automatic model_step();
        wr_t q[$];
        wr_t keep[$];
        if (m_pend) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_rw = 1'b0;
        m_wr = '0;
        m_wd = '0;
        if (m_pend) begin
            m_rw   = 1'b1;
            m_wr   = m_pend_w.r;
            m_wd   = m_pend_w.d;
            m_pend = 1'b0;
        end else begin
            if (bus.wb_req) q.push_back('{r: bus.wb_reg, d: bus.wb_data});
            if (bus.mul_req && !(bus.wb_req && bus.mul_reg == bus.wb_reg))
                q.push_back('{r: bus.mul_reg, d: bus.mul_data});
            foreach (q[i]) if (q[i].r != REG_BITS'(ZERO_REG)) keep.push_back(q[i]);
            if (keep.size() > 0) begin
                m_rw = 1'b1;
                m_wr = keep[0].r;
                m_wd = keep[0].d;
            end
            if (keep.size() > 1) begin
                m_pend   = 1'b1;
                m_pend_w = keep[1];
            end
        end
        if (m_rw) $display("tx: r%0d <= %h%s", m_wr, m_wd, m_pend ? " (mul parked)" : "");
    endtask

    // Per-cycle compare at the falling edge, then advance the model past the next rising edge.
    task automatic sample();
        @(negedge clk);
        if (!reset) model_reset();
        if (reset) begin
            chk("wb_ack",  bus.wb_ack,  m_pend ? 1'b0 : bus.wb_req);
            chk("mul_ack", bus.mul_ack, m_pend ? 1'b0 : bus.mul_req);
        end
        chk("reg_write", bus.reg_write, m_rw);
        if (m_rw || !reset) begin
            chk("write_reg",  bus.write_reg,  m_wr);
            chk("write_data", bus.write_data, m_wd);
        end
        chk("stall",        bus.stall,        m_pend);
        chk("stall_cycles", bus.stall_cycles, 64'(m_cnt));
        if (reset) model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wq, input int wr, input logic [63:0] wd,
                         input logic mq, input int mr, input logic [63:0] md);
        bus.wb_req   = wq;
        bus.wb_reg   = REG_BITS'(wr);
        bus.wb_data  = wd;
        bus.mul_req  = mq;
        bus.mul_reg  = REG_BITS'(mr);
        bus.mul_data = md;
    endtask

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(0, 9));
        return (r > 7) ? ZERO_REG : r;
    endfunction

    initial begin
        logic wb_done, mul_done;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);

        // Held in reset for a couple of cycles.
        sample();
        sample();
        advance();
        reset = 1'b1;

        // Single writeback, reg 5 = 0xAA.
        drive(1, 5, 64'hAA, 0, 0, 0);
        sample();
        chk("t2_wb_ack", bus.wb_ack, 1);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("t2_rw", bus.reg_write, 1);
        chk("t2_reg", bus.write_reg, 5);
        chk("t2_data", bus.write_data, 64'hAA);
        advance();

        // Collision on different registers; a new wb during HOLD must wait.
        drive(1, 3, 64'h11, 1, 4, 64'h22);
        sample();
        chk("t3_wb_ack", bus.wb_ack, 1);
        chk("t3_mul_ack", bus.mul_ack, 1);
        advance();
        drive(1, 9, 64'h33, 0, 0, 0);
        sample();
        chk("t3_rw1", bus.reg_write, 1);
        chk("t3_reg1", bus.write_reg, 3);
        chk("t3_data1", bus.write_data, 64'h11);
        chk("t3_stall1", bus.stall, 1);
        chk("t3_hold_wb_ack", bus.wb_ack, 0);
        advance();
        sample();
        chk("t3_reg2", bus.write_reg, 4);
        chk("t3_data2", bus.write_data, 64'h22);
        chk("t3_stall2", bus.stall, 0);
        chk("t3_late_wb_ack", bus.wb_ack, 1);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("t3_reg3", bus.write_reg, 9);
        advance();

        // WAW collision on reg 7: only the writeback lands.
        drive(1, 7, 64'h1, 1, 7, 64'h2);
        sample();
        advance();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("t4_reg", bus.write_reg, 7);
        chk("t4_data", bus.write_data, 64'h1);
        chk("t4_stall", bus.stall, 0);
        advance();
        sample();
        chk("t4_no_second", bus.reg_write, 0);
        advance();

        // XZR: acked but never written, alone or in collision.
        drive(0, 0, 0, 1, 31, 64'h5);
        sample();
        chk("t5_mul_ack", bus.mul_ack, 1);
        advance();
        drive(1, 31, 64'h6, 1, 31, 64'h7);
        sample();
        chk("t5_rw_alone", bus.reg_write, 0);
        chk("t5_both_wb_ack", bus.wb_ack, 1);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("t5_rw_both", bus.reg_write, 0);
        chk("t5_stall", bus.stall, 0);
        advance();

        // Reset asserted mid-HOLD clears everything asynchronously.
        drive(1, 1, 64'hA1, 1, 2, 64'hB2);
        sample();
        advance();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("t1_in_hold", bus.stall, 1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("t1_async_stall", bus.stall, 0);
        chk("t1_async_rw", bus.reg_write, 0);
        advance();
        reset = 1'b1;
        sample();
        chk("t1_stall", bus.stall, 0);
        chk("t1_rw", bus.reg_write, 0);
        chk("t1_cnt", bus.stall_cycles, 0);
        advance();

        // Randomized traffic; requesters hold their request until acked.
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            sample();
            wb_done  = !bus.wb_req || bus.wb_ack;
            mul_done = !bus.mul_req || bus.mul_ack;
            advance();
            if (wb_done) begin
                bus.wb_req  = ($urandom_range(0, 2) != 0);
                bus.wb_reg  = REG_BITS'(pick_reg());
                bus.wb_data = {$urandom, $urandom};
            end
            if (mul_done) begin
                bus.mul_req  = ($urandom_range(0, 1) != 0);
                bus.mul_reg  = REG_BITS'(pick_reg());
                bus.mul_data = {$urandom, $urandom};
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        sample();
        advance();
        sample();
        advance();

        // Enough collisions to push the stall counter past its top.
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            drive(1, 1, 64'(i), 1, 2, 64'(i + 1));
            sample();
            advance();
            drive(0, 0, 0, 0, 0, 0);
            sample();
            advance();
        end
        sample();
        chk("t6_saturated", bus.stall_cycles, 64'(CNT_MAX));
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
